// File: rtl/alu_cmd_sequencer.sv
// alu_cmd_sequencer: queues ALU commands in a small FIFO and issues them one
// at a time to an external ALU, waits its fixed latency, then presents the
// captured result with a valid/ready handshake.
// Optional build macro: SEQ_ILLEGAL_CMD_CHECK_EN (answer illegal commands
// with an error response instead of issuing them to the ALU).
module alu_cmd_sequencer #(
  parameter int unsigned WIDTH   = 8,
  parameter int unsigned DEPTH   = 4,
  parameter int unsigned LAT_STD = 2,
  parameter int unsigned LAT_MUL = 3
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic               s_valid,
  output logic               s_ready,
  input  logic               s_mode,
  input  logic [3:0]         s_cmd,
  input  logic [1:0]         s_inp_valid,
  input  logic [WIDTH-1:0]   s_opa,
  input  logic [WIDTH-1:0]   s_opb,
  input  logic               s_cin,
  output logic               alu_ce,
  output logic [1:0]         alu_inp_valid,
  output logic               alu_mode,
  output logic [3:0]         alu_cmd,
  output logic [WIDTH-1:0]   alu_opa,
  output logic [WIDTH-1:0]   alu_opb,
  output logic               alu_cin,
  input  logic [2*WIDTH-1:0] alu_res,
  input  logic               alu_err,
  input  logic               alu_oflow,
  input  logic               alu_cout,
  input  logic               alu_g,
  input  logic               alu_l,
  input  logic               alu_e,
  output logic               m_valid,
  input  logic               m_ready,
  output logic [2*WIDTH-1:0] m_res,
  output logic [5:0]         m_flags,
  output logic               busy
);

  localparam int unsigned AW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNTW    = AW + 1;
  localparam int unsigned EW      = 2 * WIDTH + 8;
  localparam int unsigned LAT_MAX = (LAT_MUL > LAT_STD) ? LAT_MUL : LAT_STD;
  localparam int unsigned CW      = (LAT_MAX >= 2) ? $clog2(LAT_MAX) : 1;

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;

  // FIFO entry layout: {mode, cmd[3:0], inp_valid[1:0], opa, opb, cin}
  logic [EW-1:0]   r_mem [DEPTH];
  logic [AW-1:0]   r_wr_ptr;
  logic [AW-1:0]   r_rd_ptr;
  logic [CNTW-1:0] r_count;
  logic [CW-1:0]   r_cnt;
  logic [1:0]      r_inp_valid;
  state_t          r_state;
  state_t          w_state_nxt;

  logic            w_push;
  logic            w_pop;
  logic            w_capture;
  logic            w_empty;
  logic [CNTW-1:0] w_count_nxt;
  logic            w_ce_nxt;
  logic [EW-1:0]   w_head;
  logic            w_head_mode;
  logic [3:0]      w_head_cmd;
  logic [1:0]      w_head_iv;
  logic [CW-1:0]   w_head_lat_m1;
  logic            w_head_illegal;

  assign w_empty     = (r_count == '0);
  assign w_push      = s_valid && s_ready;
  assign w_count_nxt = r_count + CNTW'(w_push) - CNTW'(w_pop);
  assign w_ce_nxt    = (w_state_nxt == S_ISSUE) || (w_state_nxt == S_WAIT);

  assign w_head      = r_mem[r_rd_ptr];
  assign w_head_mode = w_head[EW-1];
  assign w_head_cmd  = w_head[EW-2 -: 4];
  assign w_head_iv   = w_head[EW-6 -: 2];

  // Counter is loaded with L-1 on entry to ISSUE and counts down through
  // ISSUE and WAIT, so capture lands L cycles after the ISSUE cycle begins.
  assign w_head_lat_m1 = (w_head_mode && ((w_head_cmd == 4'd9) || (w_head_cmd == 4'd10)))
                         ? CW'(LAT_MUL - 1) : CW'(LAT_STD - 1);

`ifdef SEQ_ILLEGAL_CMD_CHECK_EN
  assign w_head_illegal = w_head_mode ? (w_head_cmd > 4'd10) : (w_head_cmd > 4'd13);
`else
  assign w_head_illegal = 1'b0;
`endif

  // FSM state register
  always_ff @(posedge CLK) begin
    if (RST) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  // FSM next state, FIFO pop and result capture decisions
  always_comb begin
    w_state_nxt = r_state;
    w_pop       = 1'b0;
    w_capture   = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (!w_empty) begin
          w_pop       = 1'b1;
          w_state_nxt = w_head_illegal ? S_RESP : S_ISSUE;
        end
      end
      S_ISSUE: w_state_nxt = S_WAIT;
      S_WAIT: begin
        if (r_cnt == '0) begin
          w_capture   = 1'b1;
          w_state_nxt = S_RESP;
        end
      end
      S_RESP: begin
        if (m_ready) begin
          if (!w_empty) begin
            w_pop       = 1'b1;
            w_state_nxt = w_head_illegal ? S_RESP : S_ISSUE;
          end else begin
            w_state_nxt = S_IDLE;
          end
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // FIFO storage; contents are don't-care while the pointers say empty
  always_ff @(posedge CLK) begin
    if (w_push) r_mem[r_wr_ptr] <= {s_mode, s_cmd, s_inp_valid, s_opa, s_opb, s_cin};
  end

  // FIFO pointers, latency counter and all registered outputs
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_wr_ptr      <= '0;
      r_rd_ptr      <= '0;
      r_count       <= '0;
      r_cnt         <= '0;
      r_inp_valid   <= '0;
      s_ready       <= 1'b1;
      busy          <= 1'b0;
      alu_ce        <= 1'b0;
      alu_inp_valid <= '0;
      alu_mode      <= 1'b0;
      alu_cmd       <= '0;
      alu_opa       <= '0;
      alu_opb       <= '0;
      alu_cin       <= 1'b0;
      m_valid       <= 1'b0;
      m_res         <= '0;
      m_flags       <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      r_count <= w_count_nxt;
      s_ready <= (w_count_nxt != CNTW'(DEPTH));
      busy    <= (w_count_nxt != '0) || (w_state_nxt != S_IDLE);

      if (w_pop) begin
        alu_mode    <= w_head_mode;
        alu_cmd     <= w_head_cmd;
        alu_opa     <= w_head[EW-8 -: WIDTH];
        alu_opb     <= w_head[WIDTH -: WIDTH];
        alu_cin     <= w_head[0];
        r_inp_valid <= w_head_iv;
        r_cnt       <= w_head_lat_m1;
      end else if (r_cnt != '0) begin
        r_cnt <= r_cnt - CW'(1);
      end

      alu_ce        <= w_ce_nxt;
      alu_inp_valid <= w_ce_nxt ? (w_pop ? w_head_iv : r_inp_valid) : 2'b00;
      m_valid       <= (w_state_nxt == S_RESP);

      if (w_capture) begin
        m_res   <= alu_res;
        m_flags <= {alu_err, alu_oflow, alu_cout, alu_g, alu_l, alu_e};
      end
`ifdef SEQ_ILLEGAL_CMD_CHECK_EN
      if (w_pop && w_head_illegal) begin
        m_res   <= '0;
        m_flags <= 6'b100000;
      end
`endif
    end
  end

endmodule

// File: doc/alu_cmd_sequencer.md
ALU_CMD_SEQUENCER -- requirements
Module: alu_cmd_sequencer

Interface
REQ-001 Parameters SHALL be: WIDTH, default 8, operand width; DEPTH, default 4, command queue entries (power of 2, >=2); LAT_STD, default 2, ALU latency in cycles; LAT_MUL, default 3, ALU latency for MODE=1 CMD 9/10.
REQ-002 Ports SHALL be, one per line (name direction width meaning):
- CLK  in  1  sole clock; all logic on the rising edge.
- RST  in  1  synchronous, active-high reset.
- s_valid  in  1  upstream command valid.
- s_ready  out  1  queue can accept a command.
- s_mode  in  1  ALU mode (1 = arithmetic, 0 = logical).
- s_cmd  in  4  ALU command code.
- s_inp_valid  in  2  operand-valid code passed to ALU.
- s_opa, s_opb  in  WIDTH  operands.
- s_cin  in  1  carry in.
- alu_ce  out  1  ALU clock enable.
- alu_inp_valid  out  2  ALU operand-valid code.
- alu_mode  out  1  ALU mode.
- alu_cmd  out  4  ALU command.
- alu_opa, alu_opb  out  WIDTH  ALU operands.
- alu_cin  out  1  ALU carry in.
- alu_res  in  2*WIDTH  ALU result.
- alu_err, alu_oflow, alu_cout, alu_g, alu_l, alu_e  in  1 each  ALU flags.
- m_valid  out  1  result valid.
- m_ready  in  1  downstream accepts result.
- m_res  out  2*WIDTH  captured result.
- m_flags  out  6  {err,oflow,cout,g,l,e} captured.
- busy  out  1  queue non-empty or command in flight.
REQ-003 Clock port SHALL be CLK; reset SHALL be RST, synchronous, active-high.

Function
REQ-004 A command SHALL be pushed into the DEPTH-entry FIFO when s_valid && s_ready on a rising edge; s_ready SHALL be !full, independent of s_valid.
REQ-005 FSM states SHALL be IDLE, ISSUE, WAIT, RESP; exactly one command in flight.
REQ-006 IDLE -> ISSUE when FIFO non-empty; the head is popped and latched into the alu_* outputs on that transition.
REQ-007 ISSUE SHALL last one cycle with alu_ce=1 and alu_inp_valid=latched code, then go to WAIT with counter loaded to L-1, where L = LAT_MUL if mode=1 and cmd in {9,10}, else LAT_STD.
REQ-008 In WAIT, alu_ce SHALL stay 1, all alu_* outputs SHALL hold; counter decrements each cycle; at counter==0, alu_res and flags are sampled into m_res/m_flags and state -> RESP, so capture occurs exactly L cycles after the ISSUE cycle.
REQ-009 Outside ISSUE/WAIT, alu_ce=0 and alu_inp_valid=2'b00.
REQ-010 RESP SHALL assert m_valid with m_res/m_flags stable until m_ready; on m_valid && m_ready -> ISSUE if FIFO non-empty (popping head same edge), else IDLE.
REQ-011 Push and pop on the same edge SHALL both take effect; push while full is impossible (s_ready=0); FIFO pointers wrap modulo DEPTH.
REQ-012 busy SHALL be 1 whenever FIFO non-empty or state != IDLE.
REQ-013 Upstream commands SHALL be issued in arrival order; no result is dropped or duplicated.

Reset
REQ-014 On RST=1 at a rising edge: state=IDLE, FIFO emptied, counter=0, all outputs 0 except s_ready=1.
REQ-015 RST mid-operation SHALL discard the in-flight command and queued commands; no m_valid for them.

Configuration
REQ-016 Macro SEQ_ILLEGAL_CMD_CHECK_EN: when defined, a popped command with (mode=1 and cmd>10) or (mode=0 and cmd>13) SHALL skip ISSUE/WAIT (alu_ce stays 0) and go directly to RESP with m_res=0, m_flags=6'b100000; when undefined, all commands are issued to the ALU unchanged.

Verification
REQ-017 Reset: assert RST 2 cycles -> all outputs 0, s_ready=1, busy=0.
REQ-018 Single add: mode=1 cmd=0 opa=8'h05 opb=8'h03 -> alu_ce high for 2 cycles, m_valid 3 cycles after accept with m_res captured from ALU (16'h0008).
REQ-019 Multiply latency: mode=1 cmd=9 -> capture 3 cycles after ISSUE; m_valid one cycle later than an add.
REQ-020 Back-pressure: push 5 commands with m_ready=0 -> s_ready=0 after 4 queued plus 1 in flight...; s_ready returns 1 after first m_ready handshake; results emerge in order.
REQ-021 Reset during WAIT -> m_valid never asserted for that command; busy=0 next cycle.
REQ-022 With SEQ_ILLEGAL_CMD_CHECK_EN: mode=1 cmd=4'hF -> alu_ce stays 0, m_valid next cycle, m_flags=6'b100000; without macro: alu_ce pulses and ALU flags captured.
